// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator bridging a req/rsp port to an AXI4-Lite slave.
// Latency (zero-wait slave): accept at edge 0, AW/W or AR in cycle 1, B/R in cycle 2, rsp_valid in cycle 3.
// Backpressure: req_ready only in IDLE; rsp_valid held with stable data until rsp_ready; AXI valids held until handshake.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32   // 32 or 64
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // core-side request
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  // core-side response
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  // write address channel
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [2:0]                awprot,
  // write data channel
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  // write response channel
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  // read address channel
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [2:0]                arprot,
  // read data channel
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_READ  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                    r_state,     w_state_nxt;
  logic                      r_awvalid,   w_awvalid_nxt;
  logic                      r_wvalid,    w_wvalid_nxt;
  logic                      r_bready,    w_bready_nxt;
  logic                      r_arvalid,   w_arvalid_nxt;
  logic                      r_rready,    w_rready_nxt;
  logic                      r_rsp_valid, w_rsp_valid_nxt;
  logic                      r_aw_done,   w_aw_done_nxt;
  logic                      r_w_done,    w_w_done_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr,      w_addr_nxt;
  logic [DATA_WIDTH-1:0]     r_wdata,     w_wdata_nxt;
  logic [DATA_WIDTH/8-1:0]   r_wstrb,     w_wstrb_nxt;
  logic [DATA_WIDTH-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
  logic                      r_rsp_err,   w_rsp_err_nxt;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  // Only bit 1 of the response code matters (SLVERR/DECERR); bit 0 is deliberately dropped.
  logic w_unused_resp;

  assign w_aw_hs = r_awvalid & awready;
  assign w_w_hs  = r_wvalid  & wready;
  assign w_b_hs  = bvalid    & r_bready;
  assign w_ar_hs = r_arvalid & arready;
  assign w_r_hs  = rvalid    & r_rready;
  assign w_unused_resp = bresp[0] ^ rresp[0];

  // Next-state and next-output computation; every bus-facing output is registered from these.
  always_comb begin
    w_state_nxt     = r_state;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_aw_done_nxt   = r_aw_done;
    w_w_done_nxt    = r_w_done;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_addr_nxt  = req_addr;
          w_wdata_nxt = req_wdata;
          w_wstrb_nxt = req_wstrb;
          if (req_write) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
            w_state_nxt   = S_WRITE;
          end else begin
            // rready goes up with arvalid: slaves may gate arready on rready.
            w_arvalid_nxt = 1'b1;
            w_rready_nxt  = 1'b1;
            w_state_nxt   = S_READ;
          end
        end
      end

      S_WRITE: begin
        if (w_aw_hs) begin
          w_aw_done_nxt = 1'b1;
          w_awvalid_nxt = 1'b0;
        end
        if (w_w_hs) begin
          w_w_done_nxt = 1'b1;
          w_wvalid_nxt = 1'b0;
        end
        // Both channels finished, counting a handshake landing this very cycle.
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WRESP;
        end
      end

      S_WRESP: begin
        if (w_b_hs) begin
          w_rsp_err_nxt   = bresp[1];
          w_rsp_rdata_nxt = '0;
          w_bready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end
      end

      S_READ: begin
        if (w_ar_hs) begin
          w_arvalid_nxt = 1'b0;
        end
        // R may arrive in the same cycle as the AR handshake.
        if (w_r_hs) begin
          w_rsp_rdata_nxt = rdata;
          w_rsp_err_nxt   = rresp[1];
          w_rready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign awvalid   = r_awvalid;
  assign awaddr    = r_addr;
  assign awprot    = 3'b000;
  assign wvalid    = r_wvalid;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign bready    = r_bready;
  assign arvalid   = r_arvalid;
  assign araddr    = r_addr;
  assign arprot    = 3'b000;
  assign rready    = r_rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: programmable AXI4-Lite slave, directed requests,
// scoreboard queue of expected responses popped by an independent monitor.
module tb_axi_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  initial forever #5 aclk = ~aclk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_data_q[$];
  logic        exp_err_q[$];

  // slave knobs and state
  int          aw_dly, w_dly, aw_cnt, w_cnt, b_hs_n;
  logic        s_aw_got, s_w_got, s_ar_got;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave: drive on negedge, sample handshakes 1 time unit before the posedge.
  initial begin : slave
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_cnt = 0; w_cnt = 0; b_hs_n = 0;
    s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      end else begin
        awready = awvalid && (aw_cnt >= aw_dly);
        wready  = wvalid  && (w_cnt  >= w_dly);
        bvalid  = s_aw_got && s_w_got;
        bresp   = s_bresp;
        arready = rready;
        rvalid  = s_ar_got;
        rdata   = s_rdata;
        rresp   = s_rresp;
      end
      #4;
      if (!aresetn) begin
        aw_cnt = 0; w_cnt = 0; s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
      end else begin
        if (awvalid && awready) begin s_aw_got = 1; aw_cnt = 0; end
        else if (awvalid) aw_cnt++;
        if (wvalid && wready) begin s_w_got = 1; w_cnt = 0; end
        else if (wvalid) w_cnt++;
        if (bvalid && bready) begin s_aw_got = 0; s_w_got = 0; b_hs_n++; end
        if (arvalid && arready) s_ar_got = 1;
        if (rvalid && rready) s_ar_got = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake.
  initial begin : monitor
    logic [31:0] d;
    logic        e;
    forever begin
      @(negedge aclk);
      #4;
      if (aresetn && rsp_valid && rsp_ready) begin
        if (exp_data_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata 0x%08h err %0d, required no response", rsp_rdata, rsp_err);
        end else begin
          d = exp_data_q.pop_front();
          e = exp_err_q.pop_front();
          check("rsp_rdata", rsp_rdata, d);
          check("rsp_err", 32'(rsp_err), 32'(e));
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 of cycle 1 (accept edge is edge 0).
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic expect_rsp,
                       input logic [31:0] exp_d, input logic exp_e);
    int n = 0;
    while (!req_ready && n < 100) begin @(posedge aclk); #1; n++; end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = strb;
    if (expect_rsp) begin exp_data_q.push_back(exp_d); exp_err_q.push_back(exp_e); end
    @(posedge aclk); #1;
    req_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 100) begin @(posedge aclk); #1; n++; end
    check("wait_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no end of test, required end before time 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int b0;
    aresetn = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 1; aw_dly = 0; w_dly = 0; s_rdata = 0; s_rresp = 0; s_bresp = 0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_wdata_wstrb", wdata | 32'(wstrb), 32'd0);
    check("rst_rsp", rsp_rdata | 32'(rsp_err), 32'd0);
    @(posedge aclk); #1; aresetn = 1;
    @(posedge aclk); #1;

    // Write 0x10 = 0xDEADBEEF, zero-wait slave
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, 0);
    @(negedge aclk);
    check("t1_c1_awvalid", 32'(awvalid), 32'd1);
    check("t1_c1_wvalid", 32'(wvalid), 32'd1);
    check("t1_c1_bready", 32'(bready), 32'd0);
    check("t1_c1_awaddr", awaddr, 32'h10);
    check("t1_c1_wdata", wdata, 32'hDEADBEEF);
    check("t1_c1_wstrb", 32'(wstrb), 32'hF);
    check("t1_c1_prot", 32'({awprot, arprot}), 32'd0);
    check("t1_c1_req_ready", 32'(req_ready), 32'd0);
    @(negedge aclk);
    check("t1_c2_aw_w", 32'({awvalid, wvalid}), 32'd0);
    check("t1_c2_bready", 32'(bready), 32'd1);
    check("t1_c2_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge aclk);
    check("t1_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_c3_bready", 32'(bready), 32'd0);
    @(negedge aclk);
    check("t1_c4_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t1_c4_req_ready", 32'(req_ready), 32'd1);
    @(posedge aclk); #1;

    // Read 0x10, arready tied to rready, rvalid one cycle after AR
    s_rdata = 32'hDEADBEEF; s_rresp = 2'b00;
    issue(0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0);
    @(negedge aclk);
    check("t3_c1_arvalid", 32'(arvalid), 32'd1);
    check("t3_c1_rready", 32'(rready), 32'd1);
    check("t3_c1_araddr", araddr, 32'h10);
    @(negedge aclk);
    check("t3_c2_arvalid", 32'(arvalid), 32'd0);
    check("t3_c2_rready", 32'(rready), 32'd1);
    @(negedge aclk);
    check("t3_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t3_c3_rready", 32'(rready), 32'd0);
    wait_idle();

    // Write with wready 3 cycles ahead of awready; rsp_rdata must read 0 after the read above
    w_dly = 1; aw_dly = 4; b0 = b_hs_n;
    issue(1, 32'h24, 32'h0055AA00, 4'h6, 1, 32'h0, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge aclk);
      check("t2_awvalid", 32'(awvalid), 32'd1);
      check("t2_awaddr", awaddr, 32'h24);
      check("t2_wvalid", 32'(wvalid), 32'(c <= 2));
      check("t2_bready", 32'(bready), 32'd0);
    end
    @(negedge aclk);
    check("t2_c6_awvalid", 32'(awvalid), 32'd0);
    check("t2_c6_bready", 32'(bready), 32'd1);
    @(negedge aclk);
    check("t2_c7_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_idle();
    check("t2_b_count", 32'(b_hs_n - b0), 32'd1);
    w_dly = 0; aw_dly = 0;

    // Read with SLVERR
    s_rdata = 32'h12345678; s_rresp = 2'b10;
    issue(0, 32'h20, 32'h0, 4'h0, 1, 32'h12345678, 1);
    wait_idle();

    // Response backpressure for 5 cycles
    rsp_ready = 0; s_rdata = 32'hCAFEF00D; s_rresp = 2'b00;
    issue(0, 32'h30, 32'h0, 4'h0, 1, 32'hCAFEF00D, 0);
    @(negedge aclk);
    @(negedge aclk);
    for (int c = 3; c <= 7; c++) begin
      @(negedge aclk);
      check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t5_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
      check("t5_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge aclk); #1; rsp_ready = 1;
    @(negedge aclk);
    check("t5_c8_req_ready", 32'(req_ready), 32'd0);
    @(negedge aclk);
    check("t5_c9_req_ready", 32'(req_ready), 32'd1);
    check("t5_c9_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge aclk); #1;

    // Reset mid-write aborts with no response
    aw_dly = 20; w_dly = 20;
    issue(1, 32'h50, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 0);
    @(negedge aclk);
    @(negedge aclk);
    check("t6_pre_awvalid", 32'(awvalid), 32'd1);
    #2 aresetn = 0;
    #1;
    check("t6_rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
    check("t6_rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge aclk); #1;
    @(posedge aclk); #1; aresetn = 1; aw_dly = 0; w_dly = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check("t6_post_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t6_post_req_ready", 32'(req_ready), 32'd1);
    end
    @(posedge aclk); #1;
    s_rdata = 32'h0BADF00D; s_rresp = 2'b00;
    issue(0, 32'h40, 32'h0, 4'h0, 1, 32'h0BADF00D, 0);
    wait_idle();

    repeat (3) @(posedge aclk);
    #1;
    check("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that bridges a simple request/response port to an AXI4-Lite slave, such as the on-chip block-RAM slave.
- The core-side logic issues one read or one write, then waits for a single response beat.
- The block is the master end of the same bus that the memory slaves implement.

Parameters:
ADDR_WIDTH, 32, width of req_addr, awaddr and araddr
DATA_WIDTH, 32, data width; must be 32 or 64; strobe width is DATA_WIDTH/8

Ports:
aclk  in  1  bus clock
aresetn  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  DATA_WIDTH/8  byte enables
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_err  out  1  1 if BRESP/RRESP bit 1 is set (SLVERR or DECERR)
awvalid/awready/awaddr  out/in/out  1/1/ADDR_WIDTH  write address channel
awprot  out  3  fixed 3'b000
wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel
bvalid/bready/bresp  in/out/in  1/1/2  write response channel
arvalid/arready/araddr  out/in/out  1/1/ADDR_WIDTH  read address channel
arprot  out  3  fixed 3'b000
rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_WIDTH/2  read data channel

Behaviour:
- Reset is asynchronous on the falling edge of aresetn; release is synchronous to aclk.
- Reset values: state IDLE; all valid/ready outputs 0 except req_ready, which is 1; awaddr/araddr/wdata/wstrb/rsp_rdata 0; rsp_err 0.
- States: IDLE, WRITE, WRESP, READ, RESP.
- IDLE:
  - req_ready=1; no other state asserts req_ready.
  - On acceptance, latch addr/wdata/wstrb/write.
  - req_write=1: go to WRITE, with awvalid=wvalid=1 from the next cycle (registered outputs).
  - req_write=0: go to READ, with arvalid=1 and rready=1 from the next cycle.
- WRITE:
  - AW and W complete independently; track them with flags aw_done/w_done, cleared on entry.
  - awvalid drops the cycle after its handshake; wvalid likewise.
  - Both handshakes may occur in the same cycle or in either order, with any number of cycles between them.
  - When both are done (including the same cycle as the last handshake), assert bready from the next cycle and go to WRESP.
- WRESP:
  - bready=1 until bvalid; then capture rsp_err=bresp[1], rsp_rdata=0, drop bready and go to RESP.
  - bvalid arriving before both AW and W handshakes is ignored, because bready=0 until then.
- READ:
  - rready is asserted together with arvalid, not after the AR handshake. This is mandatory because slaves may tie arready to rready; waiting for the AR handshake would deadlock.
  - arvalid drops after the AR handshake. rready stays 1 until the R handshake.
  - An R beat in the same cycle as the AR handshake is legal and is captured.
  - On the R handshake: capture rdata into rsp_rdata and rresp[1] into rsp_err, drop rready, go to RESP.
- RESP:
  - rsp_valid=1, with rsp_rdata/rsp_err stable, until rsp_ready.
  - Then go to IDLE. req_ready returns the next cycle, so there are no back-to-back accepts.
- rsp_valid is registered: it rises the cycle after the B/R handshake.
- Latency against a zero-wait slave: request accepted at edge 0; bus valid in cycle 1; B/R beat in cycle 2; rsp_valid in cycle 3.
- Once asserted, AXI valids and address/data are never changed or dropped until their handshake, as required by AXI4-Lite.
- Only one transaction is outstanding at a time.
- req_* inputs are ignored outside IDLE.
- Reset mid-transaction aborts the transaction immediately with no response; the slave is reset by the same aresetn.

Test Plan:
- Write 0x10 = 0xDEADBEEF, wstrb 0xF, slave AW/W/B always ready -> awvalid and wvalid high in cycle 1 only; bready high in cycle 2; rsp_valid in cycle 3; rsp_err=0; rsp_rdata=0.
- Write where wready rises 3 cycles before awready -> wvalid drops after its handshake; awvalid stays high with awaddr constant; bready is asserted only after the AW handshake; exactly one response.
- Read 0x10 from a slave with arready=rready and rvalid one cycle after AR -> arvalid and rready asserted together in cycle 1; rsp_valid in cycle 3 with rsp_rdata=0xDEADBEEF; no deadlock.
- Read returning rresp=2'b10 with rdata=0x12345678 -> rsp_err=1, rsp_rdata=0x12345678.
- Response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid held with stable data; req_ready=0 throughout; req_ready=1 the cycle after rsp_ready.
- aresetn pulled low while awvalid=1 in the WRITE state -> all valids 0 immediately (asynchronous), req_ready=1 after release; no rsp_valid; the next read completes normally.
